// File: rtl/seg_pkg.sv
// Shared definitions for the two-digit keypad entry block:
// segment pattern constants, key codes and the entry FSM state type.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'h7E;
  localparam logic [7:0] SEG_1     = 8'h30;
  localparam logic [7:0] SEG_2     = 8'h6D;
  localparam logic [7:0] SEG_3     = 8'h79;
  localparam logic [7:0] SEG_4     = 8'h33;
  localparam logic [7:0] SEG_5     = 8'h5B;
  localparam logic [7:0] SEG_6     = 8'h5F;
  localparam logic [7:0] SEG_7     = 8'h72;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h7B;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [3:0] KEY_CLEAR = 4'd10;
  localparam logic [3:0] KEY_ENTER = 4'd11;
  localparam logic [3:0] KEY_BSP   = 4'd12;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO,
    DONE
  } state_t;

endpackage

// File: rtl/seg_encoder.sv
// Digit to 7-segment pattern {1'b0, abcdefg}; non-digits give blank.
// Ports: digit (4b in), pattern (8b out).
module seg_encoder
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (digit)
      4'd0: pattern = SEG_0;
      4'd1: pattern = SEG_1;
      4'd2: pattern = SEG_2;
      4'd3: pattern = SEG_3;
      4'd4: pattern = SEG_4;
      4'd5: pattern = SEG_5;
      4'd6: pattern = SEG_6;
      4'd7: pattern = SEG_7;
      4'd8: pattern = SEG_8;
      4'd9: pattern = SEG_9;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_entry_ctrl.sv
// Two-digit keypad entry sequencer with a time-multiplexed display.
// Ports: clk, reset, key_valid, key_code, value_ack in;
//   seg_0, seg_1, digit_cnt, entry_done, key_err, seg_out, digit_en out.
module seg_entry_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       value_ack,
  output logic [7:0] seg_0,
  output logic [7:0] seg_1,
  output logic [1:0] digit_cnt,
  output logic       entry_done,
  output logic       key_err,
  output logic [7:0] seg_out,
  output logic [1:0] digit_en
);

  localparam int CW =
    (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  state_t        state, state_n;
  logic [7:0]    seg_0_n, seg_1_n;
  logic [1:0]    cnt_n;
  logic          err_n;
  logic          key_q;
  logic          key_ev;
  logic [7:0]    enc;
  logic [CW-1:0] scan_cnt;
  logic          wrap;
  logic          tens_n;

  seg_encoder u_enc (
    .digit   (key_code),
    .pattern (enc)
  );

  assign key_ev     = key_valid & ~key_q;
  assign entry_done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      seg_0     <= SEG_BLANK;
      seg_1     <= SEG_BLANK;
      digit_cnt <= 2'd0;
      key_err   <= 1'b0;
      key_q     <= 1'b0;
    end else begin
      state     <= state_n;
      seg_0     <= seg_0_n;
      seg_1     <= seg_1_n;
      digit_cnt <= cnt_n;
      key_err   <= err_n;
      key_q     <= key_valid;
    end
  end

  always_comb begin
    state_n = state;
    seg_0_n = seg_0;
    seg_1_n = seg_1;
    cnt_n   = digit_cnt;
    err_n   = 1'b0;
    if (state == DONE) begin
      // ack beats any key arriving in the same cycle
      if (value_ack ||
          (key_ev && key_code == KEY_CLEAR)) begin
        state_n = EMPTY;
        seg_0_n = SEG_BLANK;
        seg_1_n = SEG_BLANK;
        cnt_n   = 2'd0;
      end
    end else if (key_ev) begin
      if (key_code == KEY_CLEAR) begin
        state_n = EMPTY;
        seg_0_n = SEG_BLANK;
        seg_1_n = SEG_BLANK;
        cnt_n   = 2'd0;
      end else if (key_code <= 4'd9) begin
        case (state)
          EMPTY: begin
            seg_1_n = enc;
            state_n = ONE;
            cnt_n   = 2'd1;
          end
          ONE: begin
            seg_0_n = seg_1;
            seg_1_n = enc;
            state_n = TWO;
            cnt_n   = 2'd2;
          end
          default: err_n = 1'b1;
        endcase
      end else if (key_code == KEY_BSP) begin
        case (state)
          TWO: begin
            seg_1_n = seg_0;
            seg_0_n = SEG_BLANK;
            state_n = ONE;
            cnt_n   = 2'd1;
          end
          ONE: begin
            seg_1_n = SEG_BLANK;
            state_n = EMPTY;
            cnt_n   = 2'd0;
          end
          default: err_n = 1'b1;
        endcase
      end else if (key_code == KEY_ENTER) begin
        if (state == EMPTY) err_n = 1'b1;
        else state_n = DONE;
      end
    end
  end

  // seg_out follows the next-cycle pattern so it
  // never lags seg_0/seg_1 or digit_en
  assign wrap   = (scan_cnt == LAST);
  assign tens_n = wrap ? ~digit_en[1] : digit_en[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt <= '0;
      digit_en <= 2'b10;
      seg_out  <= SEG_BLANK;
    end else begin
      scan_cnt <= wrap ? '0 : scan_cnt + 1'b1;
      digit_en <= tens_n ? 2'b10 : 2'b01;
      seg_out  <= tens_n ? seg_0_n : seg_1_n;
    end
  end

endmodule

// File: tb/tb_seg_entry_ctrl.sv
// Directed table-driven bench for seg_entry_ctrl
// with hand-written reset, hold-key and scan sequences.
module tb_seg_entry_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       value_ack;
  logic [7:0] seg_0, seg_1, seg_out;
  logic [1:0] digit_cnt, digit_en;
  logic       entry_done, key_err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg_entry_ctrl #(.SCAN_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .value_ack  (value_ack),
    .seg_0      (seg_0),
    .seg_1      (seg_1),
    .digit_cnt  (digit_cnt),
    .entry_done (entry_done),
    .key_err    (key_err),
    .seg_out    (seg_out),
    .digit_en   (digit_en)
  );

  typedef struct {
    logic       kv;
    logic [3:0] code;
    logic       ack;
    logic [7:0] s0;
    logic [7:0] s1;
    logic [1:0] cnt;
    logic       done;
    logic       err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic kv, logic [3:0] c, logic a,
    logic [7:0] s0, logic [7:0] s1,
    logic [1:0] n, logic d, logic e);
    vec_t v;
    v.kv = kv; v.code = c; v.ack = a;
    v.s0 = s0; v.s1 = s1; v.cnt = n;
    v.done = d; v.err = e;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] bundle();
    return {12'h0, seg_0, seg_1, digit_cnt,
            entry_done, key_err};
  endfunction

  function automatic logic [31:0] expb(
    logic [7:0] s0, logic [7:0] s1,
    logic [1:0] n, logic d, logic e);
    return {12'h0, s0, s1, n, d, e};
  endfunction

  task automatic press(logic [3:0] c);
    key_valid = 1'b1; key_code = c;
    step();
    key_valid = 1'b0;
    step();
  endtask

  initial begin
    logic [7:0] eo;
    logic [1:0] ee;

    tbl.push_back(mk(1,4,0,8'h00,8'h33,1,0,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h33,1,0,0));
    tbl.push_back(mk(1,7,0,8'h33,8'h72,2,0,0));
    tbl.push_back(mk(0,0,0,8'h33,8'h72,2,0,0));
    tbl.push_back(mk(1,9,0,8'h33,8'h72,2,0,1));
    tbl.push_back(mk(0,0,0,8'h33,8'h72,2,0,0));
    tbl.push_back(mk(1,12,0,8'h00,8'h33,1,0,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h33,1,0,0));
    tbl.push_back(mk(1,7,0,8'h33,8'h72,2,0,0));
    tbl.push_back(mk(0,0,0,8'h33,8'h72,2,0,0));
    tbl.push_back(mk(1,11,0,8'h33,8'h72,2,1,0));
    tbl.push_back(mk(0,0,0,8'h33,8'h72,2,1,0));
    tbl.push_back(mk(1,3,0,8'h33,8'h72,2,1,0));
    tbl.push_back(mk(0,0,1,8'h00,8'h00,0,0,0));
    tbl.push_back(mk(1,11,0,8'h00,8'h00,0,0,1));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0,0,0));
    tbl.push_back(mk(1,12,0,8'h00,8'h00,0,0,1));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0,0,0));
    tbl.push_back(mk(1,14,0,8'h00,8'h00,0,0,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0,0,0));
    tbl.push_back(mk(1,1,0,8'h00,8'h30,1,0,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h30,1,0,0));
    tbl.push_back(mk(1,10,0,8'h00,8'h00,0,0,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0,0,0));
    tbl.push_back(mk(1,0,0,8'h00,8'h7E,1,0,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h7E,1,0,0));
    tbl.push_back(mk(1,8,0,8'h7E,8'h7F,2,0,0));
    tbl.push_back(mk(0,0,0,8'h7E,8'h7F,2,0,0));
    tbl.push_back(mk(1,13,0,8'h7E,8'h7F,2,0,0));
    tbl.push_back(mk(0,0,0,8'h7E,8'h7F,2,0,0));
    tbl.push_back(mk(1,11,0,8'h7E,8'h7F,2,1,0));
    tbl.push_back(mk(0,0,0,8'h7E,8'h7F,2,1,0));
    tbl.push_back(mk(1,12,0,8'h7E,8'h7F,2,1,0));
    tbl.push_back(mk(0,0,0,8'h7E,8'h7F,2,1,0));
    tbl.push_back(mk(1,10,0,8'h00,8'h00,0,0,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0,0,0));
    tbl.push_back(mk(1,2,1,8'h00,8'h6D,1,0,0));
    tbl.push_back(mk(0,0,1,8'h00,8'h6D,1,0,0));
    tbl.push_back(mk(1,11,0,8'h00,8'h6D,1,1,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h6D,1,1,0));
    tbl.push_back(mk(1,3,1,8'h00,8'h00,0,0,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0,0,0));
    tbl.push_back(mk(1,6,0,8'h00,8'h5F,1,0,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h5F,1,0,0));
    tbl.push_back(mk(1,9,0,8'h5F,8'h7B,2,0,0));
    tbl.push_back(mk(0,0,0,8'h5F,8'h7B,2,0,0));
    tbl.push_back(mk(1,12,0,8'h00,8'h5F,1,0,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h5F,1,0,0));
    tbl.push_back(mk(1,12,0,8'h00,8'h00,0,0,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h00,0,0,0));
    tbl.push_back(mk(1,6,0,8'h00,8'h5F,1,0,0));
    tbl.push_back(mk(0,0,0,8'h00,8'h5F,1,0,0));
    tbl.push_back(mk(1,9,0,8'h5F,8'h7B,2,0,0));
    tbl.push_back(mk(0,0,0,8'h5F,8'h7B,2,0,0));

    reset = 1'b1; key_valid = 1'b0;
    key_code = 4'd0; value_ack = 1'b0;
    step();
    chk("reset_state", bundle(),
        expb(8'h00, 8'h00, 0, 0, 0));
    chk("reset_scan", {22'h0, digit_en, seg_out},
        {22'h0, 2'b10, 8'h00});
    reset = 1'b0;

    for (int k = 1; k <= 8; k++) begin
      step();
      ee = ((k / 4) % 2 == 0) ? 2'b10 : 2'b01;
      chk($sformatf("scan_blank%0d", k),
          {22'h0, digit_en, seg_out},
          {22'h0, ee, 8'h00});
    end

    foreach (tbl[i]) begin
      key_valid = tbl[i].kv;
      key_code  = tbl[i].code;
      value_ack = tbl[i].ack;
      step();
      chk($sformatf("row%0d", i), bundle(),
          expb(tbl[i].s0, tbl[i].s1, tbl[i].cnt,
               tbl[i].done, tbl[i].err));
      eo = (digit_en == 2'b10) ? tbl[i].s0
                               : tbl[i].s1;
      chk($sformatf("row%0d_out", i),
          {24'h0, seg_out}, {24'h0, eo});
    end
    key_valid = 1'b0; value_ack = 1'b0;

    // reset while holding two digits
    reset = 1'b1;
    step();
    chk("reset_in_two", bundle(),
        expb(8'h00, 8'h00, 0, 0, 0));
    chk("reset_in_two_scan",
        {22'h0, digit_en, seg_out},
        {22'h0, 2'b10, 8'h00});
    reset = 1'b0;

    // held key gives one event
    key_valid = 1'b1; key_code = 4'd5;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("hold%0d", k), bundle(),
          expb(8'h00, 8'h5B, 1, 0, 0));
    end
    key_valid = 1'b0;
    step();
    chk("hold_release", bundle(),
        expb(8'h00, 8'h5B, 1, 0, 0));

    // scan alternation with a loaded value
    reset = 1'b1;
    step();
    reset = 1'b0;
    press(4'd4);
    press(4'd7);
    chk("load47", bundle(),
        expb(8'h33, 8'h72, 2, 0, 0));
    for (int k = 5; k <= 12; k++) begin
      step();
      ee = ((k / 4) % 2 == 0) ? 2'b10 : 2'b01;
      eo = (ee == 2'b10) ? 8'h33 : 8'h72;
      chk($sformatf("scan47_%0d", k),
          {22'h0, digit_en, seg_out},
          {22'h0, ee, eo});
    end

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
